// File: rtl/mem_window_logger.sv
// Store snooper for the PicoRV32 look-ahead bus: captures writes that land
// inside [BASE, LIMIT) through a one-stage capture register into a
// first-word-fall-through FIFO, with saturating hit/drop counters.
module mem_window_logger #(
  parameter logic [31:0] BASE  = 32'h0000_1000,
  parameter logic [31:0] LIMIT = 32'h0000_4000,
  parameter int          DEPTH = 8,
  parameter int          CNT_W = 16,
  localparam int         PW    = $clog2(DEPTH),
  localparam int         LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             flush,
  input  logic             mem_la_write,
  input  logic [31:0]      mem_la_addr,
  input  logic [31:0]      mem_la_wdata,
  input  logic [3:0]       mem_la_wstrb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // ---- stage 0: window / strobe / enable qualification ----
  logic hit_p0;
  assign hit_p0 = enable && mem_la_write && (mem_la_wstrb != 4'h0) &&
                  (mem_la_addr >= BASE) && (mem_la_addr < LIMIT);

  // ---- stage 1: capture register ----
  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [31:0] data_p1;
  logic [3:0]  strb_p1;

  // Capture valid: one-cycle pulse per hit; flush discards a hit in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    vld_p1 <= 1'b0;
    else if (flush) vld_p1 <= 1'b0;
    else            vld_p1 <= hit_p0;
  end

  // Capture payload: only meaningful while vld_p1 is set, so no reset.
  always_ff @(posedge clk) begin
    if (hit_p0) begin
      addr_p1 <= mem_la_addr;
      data_p1 <= mem_la_wdata;
      strb_p1 <= mem_la_wstrb;
    end
  end

  // ---- stage 2: FIFO ----
  logic [67:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          pop;
  logic          push;
  logic          drop;
  logic [67:0]   head;

  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready && !flush;
  assign push = vld_p1 && !flush && ((level != FULL_LVL) || pop);
  assign drop = vld_p1 && !flush && !push;

  // Pointer and occupancy bookkeeping; level is tracked separately from the pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Storage array write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr_p1, data_p1, strb_p1};
  end

  // Saturating statistics and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (hit_p0) hit_count <= sat_inc(hit_count);
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

  // Head is masked to zero while empty so stale storage never leaks out.
  assign out_valid  = (level != '0);
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_addr   = head[67:36];
  assign out_data   = head[35:4];
  assign out_strb   = head[3:0];
  assign fifo_level = level;

endmodule

// File: tb/tb_mem_window_logger.sv
// Directed bench for mem_window_logger: vector table for window/strobe/enable
// gating plus sequences for overflow, full-with-pop, back-pressure, flush, reset.
module tb_mem_window_logger;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        flush;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [3:0]  fifo_level;
  logic [15:0] hit_count;
  logic [15:0] drop_count;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  mem_window_logger dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .flush        (flush),
    .mem_la_write (mem_la_write),
    .mem_la_addr  (mem_la_addr),
    .mem_la_wdata (mem_la_wdata),
    .mem_la_wstrb (mem_la_wstrb),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_strb     (out_strb),
    .fifo_level   (fifo_level),
    .hit_count    (hit_count),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        en;
    logic        wr;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        ev;
    logic [3:0]  elvl;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [15:0] ehit;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // One in-window store with the k-indexed pattern used by the sequences.
  task automatic hit_k(input int k);
    enable       = 1'b1;
    mem_la_write = 1'b1;
    mem_la_addr  = 32'h1000 + 32'(4 * k);
    mem_la_wdata = 32'h100 + 32'(k);
    mem_la_wstrb = 4'hF;
    step();
    mem_la_write = 1'b0;
  endtask

  // Pop n entries, checking each head against the k-indexed pattern.
  task automatic drain(input int n, input int k0);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_addr", out_addr, 32'h1000 + 32'(4 * (k0 + i)));
      chk("drain_data", out_data, 32'h100 + 32'(k0 + i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] prev_a;
    logic [31:0] prev_d;
    logic        prev_stall;
    logic        rdy;
    int          sent;
    int          rcvd;
    int          cyc;

    resetn = 1'b0; enable = 1'b0; flush = 1'b0; mem_la_write = 1'b0;
    mem_la_addr = '0; mem_la_wdata = '0; mem_la_wstrb = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_hit", 32'(hit_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_strb", 32'(out_strb), 32'd0);
    resetn = 1'b1;
    step();

    // Window boundaries, then strobe / enable gating after a flush.
    vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0FFC, 32'hA0, 4'hF, 1'b0, 4'd0, 32'h0,    32'h0,  16'd0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'hA1, 4'hF, 1'b0, 4'd0, 32'h0,    32'h0,  16'd1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3FFC, 32'hA2, 4'hF, 1'b1, 4'd1, 32'h1000, 32'hA1, 16'd2};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'hA3, 4'hF, 1'b1, 4'd2, 32'h1000, 32'hA1, 16'd2};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,    32'h0,  4'h0, 1'b1, 4'd1, 32'h3FFC, 32'hA2, 16'd2};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,    32'h0,  4'h0, 1'b0, 4'd0, 32'h0,    32'h0,  16'd2};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,  4'h0, 1'b0, 4'd0, 32'h0,    32'h0,  16'd0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'hB0, 4'h0, 1'b0, 4'd0, 32'h0,    32'h0,  16'd0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'hB1, 4'hF, 1'b0, 4'd0, 32'h0,    32'h0,  16'd0};
    vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,  4'h0, 1'b0, 4'd0, 32'h0,    32'h0,  16'd0};

    for (int i = 0; i < 10; i++) begin
      flush        = vt[i].flush;
      enable       = vt[i].en;
      mem_la_write = vt[i].wr;
      out_ready    = vt[i].rdy;
      mem_la_addr  = vt[i].addr;
      mem_la_wdata = vt[i].wdata;
      mem_la_wstrb = vt[i].strb;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vt[i].elvl));
      chk($sformatf("vec%0d_addr", i), out_addr, vt[i].eaddr);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].edata);
      chk($sformatf("vec%0d_hit", i), 32'(hit_count), 32'(vt[i].ehit));
    end
    flush = 1'b0; mem_la_write = 1'b0; out_ready = 1'b0; enable = 1'b1;

    // Overflow: ten back-to-back hits into an eight-entry FIFO with no reader.
    do_flush();
    for (int k = 0; k < 10; k++) hit_k(k);
    step();
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_hit", 32'(hit_count), 32'd10);
    drain(8, 0);
    chk("ovf_empty", 32'(out_valid), 32'd0);

    // Full FIFO accepts a push when the head is popped in the same cycle.
    do_flush();
    for (int k = 0; k < 8; k++) hit_k(k);
    step();
    chk("full_level", 32'(fifo_level), 32'd8);
    hit_k(8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_drop", 32'(drop_count), 32'd0);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    drain(8, 1);
    chk("fullpop_empty", 32'(out_valid), 32'd0);

    // Random back-pressure, at most six outstanding.
    do_flush();
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    while (rcvd < 100 && cyc < 3000) begin
      if (prev_stall) begin
        chk("bp_stable_addr", out_addr, prev_a);
        chk("bp_stable_data", out_data, prev_d);
      end
      if (out_valid) begin
        if (qa.size() == 0) chk("bp_spurious", 32'(out_valid), 32'd0);
        else begin
          chk("bp_addr", out_addr, qa[0]);
          chk("bp_data", out_data, qd[0]);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy && qa.size() > 0) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        rcvd++;
      end
      prev_stall = out_valid && !rdy;
      prev_a = out_addr;
      prev_d = out_data;
      if (sent < 100 && (sent - rcvd) < 6 && $urandom_range(0, 3) != 0) begin
        mem_la_write = 1'b1;
        mem_la_addr  = 32'h2000 + 32'(4 * sent);
        mem_la_wdata = $urandom;
        mem_la_wstrb = 4'hF;
        qa.push_back(mem_la_addr);
        qd.push_back(mem_la_wdata);
        sent++;
      end else begin
        mem_la_write = 1'b0;
      end
      step();
      cyc++;
    end
    mem_la_write = 1'b0;
    out_ready = 1'b0;
    chk("bp_received", 32'(rcvd), 32'd100);
    chk("bp_hit", 32'(hit_count), 32'd100);
    chk("bp_drop", 32'(drop_count), 32'd0);

    // Flush with five queued entries, a simultaneous hit and a pop handshake.
    do_flush();
    for (int k = 0; k < 10; k++) hit_k(k);
    step();
    drain(3, 0);
    chk("fl_pre_level", 32'(fifo_level), 32'd5);
    chk("fl_pre_drop", 32'(drop_count), 32'd2);
    flush = 1'b1;
    out_ready = 1'b1;
    mem_la_write = 1'b1; mem_la_addr = 32'h1100; mem_la_wdata = 32'h55; mem_la_wstrb = 4'hF;
    step();
    flush = 1'b0; out_ready = 1'b0; mem_la_write = 1'b0;
    chk("fl_level", 32'(fifo_level), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_hit", 32'(hit_count), 32'd0);
    chk("fl_drop", 32'(drop_count), 32'd0);
    chk("fl_ovf", 32'(overflow), 32'd0);
    chk("fl_addr", out_addr, 32'd0);
    step();
    chk("fl_after_valid", 32'(out_valid), 32'd0);
    chk("fl_after_level", 32'(fifo_level), 32'd0);
    chk("fl_after_hit", 32'(hit_count), 32'd0);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 10; k++) hit_k(k);
    step();
    chk("ar_pre_level", 32'(fifo_level), 32'd8);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_level", 32'(fifo_level), 32'd0);
    chk("ar_hit", 32'(hit_count), 32'd0);
    chk("ar_drop", 32'(drop_count), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_addr", out_addr, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_strb", 32'(out_strb), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_window_logger.md
# mem_window_logger

Bus-snooping write logger for the PicoRV32 SoC. It watches the core's look-ahead memory interface and captures every store whose address falls inside a configurable window (default 0x1000–0x3FFF). Each capture goes through a one-stage capture register into a first-word-fall-through FIFO. A downstream consumer (UART dumper, display driver, testbench monitor) drains the FIFO over a valid/ready handshake. The block also keeps saturating hit and drop counters for the window.

## Interface
Parameters:
- BASE, 32'h0000_1000: inclusive lower bound of the capture window.
- LIMIT, 32'h0000_4000: exclusive upper bound; BASE < LIMIT.
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CNT_W, 16: width of hit and drop counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; when 0, no new hits are recognised.
- flush  in  1  synchronous clear of FIFO, capture register, counters and overflow.
- mem_la_write  in  1  PicoRV32 look-ahead write strobe, one cycle per store.
- mem_la_addr  in  32  look-ahead address.
- mem_la_wdata  in  32  look-ahead write data.
- mem_la_wstrb  in  4  look-ahead byte strobes.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_addr  out  32  head address (full byte address as written).
- out_data  out  32  head write data.
- out_strb  out  4  head byte strobes.
- fifo_level  out  $clog2(DEPTH)+1  current number of FIFO entries, 0..DEPTH.
- hit_count  out  CNT_W  window hits seen, saturating.
- drop_count  out  CNT_W  hits lost to a full FIFO, saturating.
- overflow  out  1  sticky; set on the first drop.

## Operation
- **Hit.** A hit requires all of the following in the same cycle:
  - enable = 1
  - mem_la_write = 1
  - mem_la_wstrb ≠ 0
  - BASE ≤ mem_la_addr < LIMIT (unsigned 32-bit compares)
- **Capture register (stage 1).** On a hit, {addr, wdata, wstrb} are latched and cap_valid is set for one cycle. hit_count increments, saturating at 2^CNT_W−1.
- **FIFO push (stage 2).** When cap_valid = 1, the entry is pushed if level < DEPTH, or if level = DEPTH and a pop occurs in the same cycle.
- **Drop.** If the push is not accepted, the entry is discarded. drop_count increments (saturating) and overflow is set.
- **Pop.** A pop occurs when out_valid && out_ready.
- **Simultaneous push and pop.**
  - Level is unchanged.
  - When empty, no bypass: the pushed entry appears at the head the next cycle.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally. fifo_level is a separate counter: +1 on push only, −1 on pop only.
- **Flush** (flush = 1 at a rising edge):
  - level → 0, pointers → 0, cap_valid → 0.
  - hit_count, drop_count and overflow → 0.
  - A hit in the same cycle is discarded and not counted.
  - A pop handshake in the same cycle is ignored.
- **enable deassertion** does not affect a hit already in the capture register or entries already in the FIFO.
- **Reset values** (resetn = 0, asynchronous): out_valid 0, fifo_level 0, hit_count 0, drop_count 0, overflow 0. out_addr, out_data and out_strb read 0 while empty after reset. Storage array contents are don't-care.

## Timing
- Latency from hit to out_valid with the FIFO empty: 2 cycles. A hit sampled at edge N gives cap_valid after N; the push happens at edge N+1, so out_valid = 1 after N+1.
- Throughput: one hit per cycle accepted while not full.
- out_* payload must stay stable while out_valid && !out_ready.
- out_valid depends only on registered state. There is no combinational path from out_ready to out_valid, or from mem_la_* to any output.
- drop_count and overflow update at the edge where the push is refused, i.e. one cycle after the hit.
- Reset is asserted asynchronously. Deassertion is assumed synchronised externally.

## Test plan
1. **Window boundaries.** Writes to 0x0FFC, 0x1000, 0x3FFC and 0x4000, with wstrb = 4'hF and data 0xA0..0xA3 respectively.
   - Exactly two entries: (0x1000, 0xA1) then (0x3FFC, 0xA2).
   - hit_count = 2.
   - out_valid rises 2 cycles after the 0x1000 write.
2. **Strobe and enable gating.**
   - An in-window write with wstrb = 0 produces no entry.
   - An in-window write with enable = 0 produces no entry.
   - hit_count stays 0.
3. **Overflow.** With out_ready = 0, issue 10 back-to-back hits at 0x1000+4k (k = 0..9).
   - fifo_level = 8, drop_count = 2, overflow = 1.
   - Draining yields k = 0..7 in order.
4. **Full with concurrent pop.** FIFO full (8 entries), out_ready = 1 in the cycle a 9th capture pushes.
   - No drop; level stays 8.
   - The 9th entry appears as the 8th read after the current head.
5. **Back-pressure stability.** Toggle out_ready randomly for 100 hits with at most 6 outstanding.
   - All 100 entries are read in order with no loss.
   - Payload is unchanged during stalls.
   - hit_count = 100.
6. **Flush and reset mid-operation.**
   - Flush with 5 entries queued and a simultaneous hit: level 0, out_valid 0, all counters 0, overflow 0 on the next cycle.
   - resetn pulsed low mid-stream: all outputs go to their reset values immediately, without waiting for a clock edge.
